// File: rtl/traffic_sensor_conditioner.sv
// Conditions two raw vehicle-loop lines into clean occupancy flags Ta/Tb plus stuck-on faults.
// Latency: 3+DEB_TICKS cycles rise, +HOLD_TICKS ticks fall (tick tied high); no backpressure.
module traffic_sensor_conditioner #(
    parameter int DEB_TICKS   = 4,
    parameter int HOLD_TICKS  = 3,
    parameter int STUCK_TICKS = 1000,
    parameter int CW          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sa_raw,
    input  logic sb_raw,
    output logic Ta,
    output logic Tb,
    output logic fault_a,
    output logic fault_b
);

    typedef enum logic [1:0] {IDLE, OCC, HOLD, FAULT} state_t;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEB_T   = CW'(DEB_TICKS);
    localparam logic [CW-1:0] HOLD_T  = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] STUCK_T = CW'(STUCK_TICKS);

    logic [1:0]    raw, s1, s2, deb, deb_flip;
    logic [CW-1:0] dcnt [2];
    logic [CW-1:0] dinc [2];
    logic [CW-1:0] cnt [2];
    logic [CW-1:0] cinc [2];
    logic [CW-1:0] cnt_nxt [2];
    state_t        state [2];
    state_t        state_nxt [2];
    logic [1:0]    t_q, f_q;

    assign raw = {sb_raw, sa_raw};

    // deb_flip: the debouncer commits a new value at this edge; the FSM uses it
    // so a pending deb change wins over a count expiring in the same cycle.
    for (genvar g = 0; g < 2; g++) begin : g_inc
        assign dinc[g]     = dcnt[g] + ONE;
        assign cinc[g]     = cnt[g] + ONE;
        assign deb_flip[g] = (s2[g] != deb[g]) && tick && (dinc[g] == DEB_T);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            deb <= '0;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (tick) begin
                    if (deb_flip[i]) begin
                        deb[i]  <= s2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dinc[i];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                IDLE: begin
                    if (deb[i]) begin
                        state_nxt[i] = OCC;
                        cnt_nxt[i]   = '0;
                    end
                end
                OCC: begin
                    if (!deb[i]) begin
                        state_nxt[i] = HOLD;
                        cnt_nxt[i]   = '0;
                    end else if (tick) begin
                        if (cnt[i] != STUCK_T) cnt_nxt[i] = cinc[i];
                        if (cinc[i] == STUCK_T && !deb_flip[i]) state_nxt[i] = FAULT;
                    end
                end
                HOLD: begin
                    if (deb[i]) begin
                        state_nxt[i] = OCC;
                        cnt_nxt[i]   = '0;
                    end else if (HOLD_TICKS == 0) begin
                        if (!deb_flip[i]) state_nxt[i] = IDLE;
                    end else if (tick) begin
                        if (cnt[i] != HOLD_T) cnt_nxt[i] = cinc[i];
                        if (cinc[i] == HOLD_T && !deb_flip[i]) state_nxt[i] = IDLE;
                    end
                end
                FAULT: begin
                    if (!deb[i]) state_nxt[i] = IDLE;
                end
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= '0;
            f_q <= '0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
                t_q[i]   <= (state_nxt[i] == OCC) || (state_nxt[i] == HOLD);
                f_q[i]   <= (state_nxt[i] == FAULT);
            end
        end
    end

    assign Ta      = t_q[0];
    assign Tb      = t_q[1];
    assign fault_a = f_q[0];
    assign fault_b = f_q[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner; STUCK_TICKS reduced to 20, other parameters default.
module tb_traffic_sensor_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b1;
    logic sa_raw = 1'b0;
    logic sb_raw = 1'b0;
    logic Ta, Tb, fault_a, fault_b;

    int total = 0;
    int bad   = 0;

    traffic_sensor_conditioner #(
        .DEB_TICKS  (4),
        .HOLD_TICKS (3),
        .STUCK_TICKS(20),
        .CW         (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .sa_raw (sa_raw),
        .sb_raw (sb_raw),
        .Ta     (Ta),
        .Tb     (Tb),
        .fault_a(fault_a),
        .fault_b(fault_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        tick   = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // reset with both lines high
        sa_raw = 1'b1;
        sb_raw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reset_hold", {4'b0, Ta, Tb, fault_a, fault_b}, 8'h00);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("reset_rise", {4'b0, Ta, Tb, fault_a, fault_b},
                (k == 7) ? 8'b0000_1100 : 8'h00);
        end

        // glitch shorter than DEB_TICKS is rejected
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            sa_raw = (k <= 3);
            step();
            chk("glitch", {6'b0, Ta, Tb}, 8'h00);
        end
        for (int k = 1; k <= 8; k++) begin
            sa_raw = 1'b1;
            step();
            chk("deb_rise", {6'b0, Ta, Tb}, (k >= 7) ? 8'b10 : 8'b00);
        end

        // 4-cycle gap is bridged by hold
        for (int k = 1; k <= 14; k++) begin
            sa_raw = (k >= 5);
            step();
            chk("gap", {6'b0, Ta, Tb}, 8'b10);
        end
        // sustained low: Ta falls 10 edges after first low sample
        for (int k = 1; k <= 12; k++) begin
            sa_raw = 1'b0;
            step();
            chk("fall", {6'b0, Ta, fault_a}, (k < 10) ? 8'b10 : 8'b00);
        end

        // stuck-on channel B
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            sb_raw = 1'b1;
            step();
            chk("stuck", {5'b0, Ta, Tb, fault_b},
                (k >= 27) ? 8'b001 : ((k >= 7) ? 8'b010 : 8'b000));
        end
        for (int k = 1; k <= 9; k++) begin
            sb_raw = 1'b0;
            step();
            chk("stuck_clear", {6'b0, Tb, fault_b}, (k < 7) ? 8'b01 : 8'b00);
        end

        // sparse tick: one pulse every 4th cycle
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            tick   = ((k % 4) == 3);
            sa_raw = 1'b1;
            step();
            chk("sparse", {6'b0, Ta, Tb}, (k >= 16) ? 8'b10 : 8'b00);
        end
        tick = 1'b1;

        // reset with A in HOLD and B in FAULT
        do_reset();
        for (int k = 1; k <= 29; k++) begin
            sb_raw = 1'b1;
            sa_raw = (k >= 10) && (k < 22);
            step();
        end
        chk("pre_rst", {4'b0, Ta, Tb, fault_a, fault_b}, 8'b0000_1001);
        rst = 1'b1;
        step();
        chk("mid_rst", {4'b0, Ta, Tb, fault_a, fault_b}, 8'h00);
        rst    = 1'b0;
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst", {4'b0, Ta, Tb, fault_a, fault_b}, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
